// File: rtl/counter_pkg.sv
// Shared definitions for the cascadable modulo-N counter: count direction
// encoding, a constant log2 helper and the single-digit next-value rule.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Next value of one digit when it is allowed to step. Illegal values
    // (>= modulus) are treated as terminal going up and reload to the top
    // going down, so a digit always recovers into the legal range.
    function automatic int digit_next(input int val, input logic up, input int modulus);
        if (up == DIR_UP) begin
            return (val >= modulus - 1) ? 0 : val + 1;
        end
        return (val == 0 || val >= modulus) ? modulus - 1 : val - 1;
    endfunction

endpackage

// File: rtl/mod_digit.sv
// One counter digit: register with clear > load > step priority, plus the
// direction-dependent terminal-count detect used by the carry chain.
module mod_digit
    import counter_pkg::*;
#(
    parameter int DIGIT_W = 4,
    parameter int MODULUS = 10
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic               step_en,
    input  logic               up,
    input  logic               load,
    input  logic               clr,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] q_nxt;

    assign q_nxt = DIGIT_W'(digit_next(int'(q), up, MODULUS));

    // Up mode counts anything at or above the top value as terminal.
    assign term = (up == DIR_DOWN) ? (q == '0) : (q >= LAST);

    // Digit register: clear beats load beats step; otherwise hold.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (step_en) begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/mod_counter_cascade.sv
// Cascadable modulo-N up/down counter. A free-running prescaler makes a
// one-cycle tick; all digit updates happen only on ticks. tc/rco follow
// 74x161 semantics: gated by ent only, independent of enp and tick.
module mod_counter_cascade
    import counter_pkg::*;
#(
    parameter int DIGIT_W  = 4,
    parameter int DIGITS   = 2,
    parameter int MODULUS  = 10,
    parameter int PRESCALE = 25_000_000,
    parameter int PRE_W    = 25
) (
    input  logic                      clk_50M,
    input  logic                      rst_n,
    input  logic                      sclr_n,
    input  logic                      ld_n,
    input  logic                      ent,
    input  logic                      enp,
    input  logic                      up,
    input  logic [DIGITS*DIGIT_W-1:0] d,
    output logic                      tick,
    output logic [DIGITS*DIGIT_W-1:0] q,
    output logic [DIGITS-1:0]         tc,
    output logic                      rco
);

    // Never narrower than PRESCALE needs, even if PRE_W is set too small.
    localparam int CNT_W = (PRE_W > clog2(PRESCALE)) ? PRE_W : clog2(PRESCALE);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0]  pre_cnt;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] low_ok;
    logic              do_clr;
    logic              do_load;
    logic              do_count;

    // Prescaler wraps at PRESCALE-1; tick is high for the following cycle.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + CNT_W'(1);
        end
    end

    assign do_clr   = tick & ~sclr_n;
    assign do_load  = tick & ~ld_n;
    assign do_count = tick & ent & enp;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsb
                assign low_ok[i] = 1'b1;
            end else begin : g_upper
                assign low_ok[i] = &term[i-1:0];
            end

            assign tc[i] = ent & term[i] & low_ok[i];

            mod_digit #(
                .DIGIT_W (DIGIT_W),
                .MODULUS (MODULUS)
            ) u_digit (
                .clk_50M (clk_50M),
                .rst_n   (rst_n),
                .step_en (do_count & low_ok[i]),
                .up      (up),
                .load    (do_load),
                .clr     (do_clr),
                .d       (d[i*DIGIT_W +: DIGIT_W]),
                .q       (q[i*DIGIT_W +: DIGIT_W]),
                .term    (term[i])
            );
        end
    endgenerate

    assign rco = tc[DIGITS-1];

endmodule
